invader_grid_tracker: RTL
=========================

Name: invader_grid_tracker

Overview:
Tracks which invaders in the formation are alive and resolves player shots against the formation. It consumes the formation origin (xpos/ypos) produced by the invader movement block and shot coordinates from the player-bullet logic. It returns hit/miss results, a score increment, the alive mask for the renderer, and game-over flags (all_dead, invaded).

Parameters:
ROWS, 5, formation rows (row 0 = top)
COLS, 11, formation columns (col 0 = left)
CELL_W, 32, horizontal cell pitch in px; must be a power of 2
CELL_H, 32, vertical cell pitch in px; must be a power of 2
INV_W, 24, invader sprite width in px inside a cell (< CELL_W)
INV_H, 16, invader sprite height in px inside a cell (< CELL_H)
BOTTOM_Y, 700, y line that triggers invaded

Ports:
clk65MHz  in  1  system clock
rst  in  1  asynchronous, active-high reset
game_start  in  1  level; arms the formation while in IDLE
xpos  in  10  formation origin x (top-left of cell 0,0)
ypos  in  10  formation origin y
shot_valid  in  1  shot request; held until accepted
shot_x  in  10  shot tip x, screen px
shot_y  in  10  shot tip y, screen px
shot_ready  out  1  tracker can accept a shot
hit  out  1  one-cycle pulse: shot destroyed an invader
miss  out  1  one-cycle pulse: shot hit nothing
hit_row  out  3  row of the last hit
hit_col  out  4  column of the last hit
score_add  out  6  points for the last hit; valid with hit
alive_mask  out  ROWS*COLS  bit r*COLS+c = invader (r,c) alive
alive_count  out  7  number of alive invaders
all_dead  out  1  alive_count == 0 while armed
invaded  out  1  lowest alive row has reached BOTTOM_Y

Behaviour:
- Reset (async, active-high; immediate effect): state IDLE; alive_mask=0; alive_count=0; all outputs=0; any in-flight shot is discarded and no hit/miss pulse is emitted for it.
- FSM states: IDLE, READY, CALC, TEST.
- IDLE: shot_ready=0. When game_start=1, the next edge sets alive_mask to all ones, sets alive_count=ROWS*COLS, and moves to READY. game_start is ignored in every other state.
- READY: shot_ready=1. A handshake (shot_valid && shot_ready) at edge E0 captures shot_x, shot_y, xpos and ypos into snapshot registers and moves to CALC. Later changes to xpos/ypos do not affect that shot.
- CALC (one cycle), computed from the snapshots:
  - rel_x = shot_x - x_snap and rel_y = shot_y - y_snap, 11-bit signed.
  - out_of_grid if rel_x < 0, rel_y < 0, rel_x >= COLS*CELL_W, or rel_y >= ROWS*CELL_H.
  - col = rel_x >> log2(CELL_W); row = rel_y >> log2(CELL_H).
  - off_x/off_y = low log2 bits of rel_x/rel_y.
  - Results are registered; the FSM moves to TEST at E1.
- TEST: is_hit = !out_of_grid && off_x < INV_W && off_y < INV_H && alive_mask[row*COLS+col].
- At edge E2:
  - On a hit: clear that alive bit; decrement alive_count; hit=1; load hit_row/hit_col; load score_add.
  - score_add by row: row 0 = 30, rows 1–2 = 20, rows ≥3 = 10.
  - Otherwise: miss=1; hit_row, hit_col and score_add hold their previous values.
  - Move to READY in either case.
- Timing: hit/miss is high for exactly the cycle after E2, i.e. 3 edges after acceptance. shot_ready is 0 during CALC/TEST and returns to 1 in that same cycle.
- Shots while shot_ready=0 are not accepted; the requester must hold shot_valid.
- all_dead: registered; 1 when alive_count==0 and state != IDLE. Shots are still accepted afterwards and all return miss.
- invaded: registered, updated every cycle from the live ypos.
  - r_max = highest row index with any alive bit.
  - invaded = any alive && (ypos + r_max*CELL_H + INV_H >= BOTTOM_Y), evaluated in 11-bit unsigned.
  - 0 when nothing is alive. One cycle latency after a ypos or mask change.
- A hit to an already-dead cell (gap) is a miss. Shots exactly on a cell boundary follow the >= rules above.

Test Plan:
1. Assert rst mid-run → alive_mask=0, shot_ready=0, no pulses. Release rst, game_start=1 → next edge: alive_mask all 55 ones, alive_count=55, shot_ready=1.
2. xpos=100, ypos=50, shot (110,60) → hit 3 edges after accept, hit_row=0, hit_col=0, score_add=30, bit0 cleared, alive_count=54. Same shot again → miss.
3. xpos=100, ypos=50, miss cases:
   - shot (130,60): off_x=30 ≥ 24 → miss.
   - shot (99,60): negative rel_x → miss.
   - shot (452,60): rel_x=352 → miss.
   - alive_count unchanged after all three.
4. Shot (425,183) → hit_row=4, hit_col=10, bit 54 cleared, score_add=10. Hold shot_valid while changing xpos during CALC → result uses the snapshot xpos.
5. Invaded threshold, full formation:
   - ypos=555 → invaded=0; ypos=556 → invaded=1 one cycle later.
   - Kill all 11 row-4 invaders → invaded=0 (556+96+16=668 < 700).
6. Destroy all 55 invaders → alive_count=0, all_dead=1, invaded=0, subsequent shots → miss. Assert rst during CALC of a shot → no hit/miss pulse, state IDLE.

Source files
------------

// File: rtl/invader_grid_tracker.sv
// Alive-mask tracker for the invader formation; resolves one player shot at a time.
// Latency: hit/miss pulse registers 3 edges after the shot handshake; invaded/all_dead lag by 1 cycle.
// Backpressure: shot_ready drops while a shot is resolved, and shot_valid must be held until accepted.
module invader_grid_tracker #(
  parameter int ROWS     = 5,
  parameter int COLS     = 11,
  parameter int CELL_W   = 32,
  parameter int CELL_H   = 32,
  parameter int INV_W    = 24,
  parameter int INV_H    = 16,
  parameter int BOTTOM_Y = 700
) (
  input  logic                 clk65MHz,
  input  logic                 rst,
  input  logic                 game_start,
  input  logic [9:0]           xpos,
  input  logic [9:0]           ypos,
  input  logic                 shot_valid,
  input  logic [9:0]           shot_x,
  input  logic [9:0]           shot_y,
  output logic                 shot_ready,
  output logic                 hit,
  output logic                 miss,
  output logic [2:0]           hit_row,
  output logic [3:0]           hit_col,
  output logic [5:0]           score_add,
  output logic [ROWS*COLS-1:0] alive_mask,
  output logic [6:0]           alive_count,
  output logic                 all_dead,
  output logic                 invaded
);

  localparam int NCELL  = ROWS * COLS;
  localparam int CW_LOG = $clog2(CELL_W);
  localparam int CH_LOG = $clog2(CELL_H);
  localparam int IDX_W  = $clog2(NCELL);

  typedef enum logic [1:0] {IDLE, READY, CALC, TEST} state_t;
  state_t state;

  logic [9:0]        shot_x_q, shot_y_q, x_snap, y_snap;
  logic signed [10:0] rel_x, rel_y;
  logic              out_of_grid, oog_q;
  logic [2:0]        row_q;
  logic [3:0]        col_q;
  logic [CW_LOG-1:0] off_x_q;
  logic [CH_LOG-1:0] off_y_q;

  logic [IDX_W-1:0]  cell_idx;
  logic              cell_alive, is_hit;
  logic [5:0]        score_sel;

  logic [2:0]        r_max;
  logic              any_alive;
  logic [10:0]       bottom_y;

  // Shot position relative to the snapshotted formation origin.
  always_comb begin
    rel_x = $signed({1'b0, shot_x_q}) - $signed({1'b0, x_snap});
    rel_y = $signed({1'b0, shot_y_q}) - $signed({1'b0, y_snap});
    out_of_grid = rel_x[10] || rel_y[10]
               || ($unsigned(rel_x) >= 11'(COLS * CELL_W))
               || ($unsigned(rel_y) >= 11'(ROWS * CELL_H));
  end

  always_comb begin
    cell_idx   = IDX_W'(row_q) * IDX_W'(COLS) + IDX_W'(col_q);
    cell_alive = (int'(cell_idx) < NCELL) ? alive_mask[cell_idx] : 1'b0;
    is_hit     = !oog_q && (off_x_q < CW_LOG'(INV_W)) && (off_y_q < CH_LOG'(INV_H)) && cell_alive;
    if (row_q == 3'd0)
      score_sel = 6'd30;
    else if (row_q <= 3'd2)
      score_sel = 6'd20;
    else
      score_sel = 6'd10;
  end

  // Lowest occupied row decides how far down the formation reaches.
  always_comb begin
    r_max = '0;
    for (int r = 0; r < ROWS; r++)
      if (|alive_mask[r*COLS +: COLS])
        r_max = 3'(r);
    any_alive = |alive_mask;
    bottom_y  = {1'b0, ypos} + (11'(r_max) << CH_LOG) + 11'(INV_H);
  end

  always_ff @(posedge clk65MHz or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shot_ready  <= 1'b0;
      hit         <= 1'b0;
      miss        <= 1'b0;
      hit_row     <= '0;
      hit_col     <= '0;
      score_add   <= '0;
      alive_mask  <= '0;
      alive_count <= '0;
      all_dead    <= 1'b0;
      invaded     <= 1'b0;
      shot_x_q    <= '0;
      shot_y_q    <= '0;
      x_snap      <= '0;
      y_snap      <= '0;
      oog_q       <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      off_x_q     <= '0;
      off_y_q     <= '0;
    end else begin
      hit      <= 1'b0;
      miss     <= 1'b0;
      all_dead <= (alive_count == 7'd0) && (state != IDLE);
      invaded  <= any_alive && (bottom_y >= 11'(BOTTOM_Y));
      case (state)
        IDLE: begin
          if (game_start) begin
            alive_mask  <= '1;
            alive_count <= 7'(NCELL);
            shot_ready  <= 1'b1;
            state       <= READY;
          end
        end
        READY: begin
          if (shot_valid && shot_ready) begin
            shot_x_q   <= shot_x;
            shot_y_q   <= shot_y;
            x_snap     <= xpos;
            y_snap     <= ypos;
            shot_ready <= 1'b0;
            state      <= CALC;
          end
        end
        CALC: begin
          oog_q   <= out_of_grid;
          col_q   <= rel_x[CW_LOG +: 4];
          row_q   <= rel_y[CH_LOG +: 3];
          off_x_q <= rel_x[CW_LOG-1:0];
          off_y_q <= rel_y[CH_LOG-1:0];
          state   <= TEST;
        end
        TEST: begin
          if (is_hit) begin
            alive_mask[cell_idx] <= 1'b0;
            alive_count          <= alive_count - 7'd1;
            hit                  <= 1'b1;
            hit_row              <= row_q;
            hit_col              <= col_q;
            score_add            <= score_sel;
          end else begin
            miss <= 1'b1;
          end
          shot_ready <= 1'b1;
          state      <= READY;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
